// File: rtl/mx_dot_acc.sv
// mx_dot_acc: MX block dot-product accumulator.
// Sums block_size signed element products into one wide result. The result is
// paired with the combined E8M0 shared scale of the two operand blocks and a
// NaN flag, then held in a registered valid/ready output stage.
module mx_dot_acc #(
  parameter int exp_width  = 5,
  parameter int man_width  = 2,
  parameter int prd_width  = 2*((1<<exp_width)+man_width+2),
  parameter int block_size = 32,
  parameter int scl_width  = 8,
  parameter int acc_width  = prd_width + $clog2(block_size)
) (
  input  logic                        i_clk,
  input  logic                        i_rst_n,
  input  logic                        i_valid,
  output logic                        o_ready,
  input  logic signed [prd_width-1:0] i_prd,
  input  logic        [scl_width-1:0] i_scl0,
  input  logic        [scl_width-1:0] i_scl1,
  output logic                        o_valid,
  input  logic                        i_ready,
  output logic signed [acc_width-1:0] o_sum,
  output logic          [scl_width:0] o_scl,
  output logic                        o_nan
);

  localparam int                   cnt_width = $clog2(block_size);
  localparam logic [cnt_width-1:0] cnt_last  = cnt_width'(block_size - 1);
  localparam logic [scl_width-1:0] scl_nan   = '1;

  logic        [cnt_width-1:0] cnt;
  logic signed [acc_width-1:0] acc;
  logic        [scl_width-1:0] scl0_q;
  logic        [scl_width-1:0] scl1_q;

  logic                        accept;
  logic                        first_beat;
  logic                        last_beat;
  logic                        consume;
  logic signed [acc_width-1:0] prd_ext;
  logic signed [acc_width-1:0] acc_sum;

  // The guard bits in acc_width cover the growth from block_size additions,
  // so the running sum never needs saturation.
  assign prd_ext    = {{(acc_width-prd_width){i_prd[prd_width-1]}}, i_prd};
  assign acc_sum    = acc + prd_ext;
  assign first_beat = (cnt == '0);
  assign last_beat  = (cnt == cnt_last);
  assign consume    = o_valid && i_ready;

  // Only the closing beat can collide with an unconsumed result; every other
  // beat flows freely. cnt resets to 0, so o_ready reads 1 during reset.
  assign o_ready = !(last_beat && o_valid && !i_ready);
  assign accept  = i_valid && o_ready;

  // Beat counter and running accumulator; the first beat of a block restarts
  // the sum and captures the shared scales.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others, independent of block order.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cnt    <= '0;
      acc    <= '0;
      scl0_q <= '0;
      scl1_q <= '0;
    end else if (accept) begin
      cnt <= last_beat ? '0 : cnt + 1'b1;
      if (first_beat) begin
        acc    <= prd_ext;
        scl0_q <= i_scl0;
        scl1_q <= i_scl1;
      end else begin
        acc <= acc_sum;
      end
    end
  end

  // Output register: loads on the last beat, which may coincide with the
  // consume of the previous result; otherwise clears valid on consume.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_valid <= 1'b0;
      o_sum   <= '0;
      o_scl   <= '0;
      o_nan   <= 1'b0;
    end else if (accept && last_beat) begin
      o_valid <= 1'b1;
      o_sum   <= acc_sum;
      o_scl   <= {1'b0, scl0_q} + {1'b0, scl1_q};
      o_nan   <= (scl0_q == scl_nan) || (scl1_q == scl_nan);
    end else if (consume) begin
      o_valid <= 1'b0;
    end
  end

endmodule
